// File: rtl/fifo_ctrl_4x8_pkg.sv
// Shared sizing for the 4x8 FIFO controller and the storage array it drives.
package fifo_ctrl_4x8_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int MAIN_SIZE_DEF = 4;
  localparam int ADDR_SIZE_DEF = 2;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ptr_4.sv
// Modulo-MAIN_SIZE incrementing pointer with enable; used for both FIFO addresses.
module fifo_ptr_4
  import fifo_ctrl_4x8_pkg::*;
#(
  parameter int MAIN_SIZE = MAIN_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  output logic [ADDR_SIZE-1:0] ptr_o
);

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MAIN_SIZE - 1);

  logic [ADDR_SIZE-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_SIZE'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl_4x8.sv
// Pointer/flag controller in front of the 4x8 FIFO storage: acceptance, strobes,
// occupancy count, threshold flags and sticky overflow/underflow.
module fifo_ctrl_4x8
  import fifo_ctrl_4x8_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int MAIN_SIZE = MAIN_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE:0]   umbral_af,
  input  logic [ADDR_SIZE:0]   umbral_ae,
  output logic                 mem_write,
  output logic                 mem_read,
  output logic [ADDR_SIZE-1:0] wr_ptr,
  output logic [ADDR_SIZE-1:0] rd_ptr,
  output logic [DATA_SIZE-1:0] mem_data,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   fifo_count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE+1)'(MAIN_SIZE);
  localparam logic [ADDR_SIZE:0] ONE      = (ADDR_SIZE+1)'(1);

  logic [ADDR_SIZE:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               do_push, do_pop;
  fifo_op_e           op;

  // Gating with reset keeps the strobes quiet while reset is held, even though
  // the count is already zero and would block pops on its own.
  assign do_pop  = pop & ~empty & reset;
  assign do_push = push & (~full | do_pop) & reset;
  assign op      = fifo_op_e'({do_push, do_pop});

  always_comb begin
    count_d = count_q;
    unique case (op)
      OP_PUSH: count_d = count_q + ONE;
      OP_POP:  count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push & ~do_push);
    unf_d = unf_q | (pop & ~do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_ptr_4 #(.MAIN_SIZE(MAIN_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_wr_ptr (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (do_push),
    .ptr_o  (wr_ptr)
  );

  fifo_ptr_4 #(.MAIN_SIZE(MAIN_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_rd_ptr (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (do_pop),
    .ptr_o  (rd_ptr)
  );

  assign mem_write    = do_push;
  assign mem_read     = do_pop;
  assign mem_data     = data_in;
  assign fifo_count   = count_q;
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= umbral_af);
  assign almost_empty = (count_q <= umbral_ae);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_4x8.sv
// Bench for fifo_ctrl_4x8: reference model plus storage/scoreboard queue for read data.
module tb_fifo_ctrl_4x8;
  import fifo_ctrl_4x8_pkg::*;

  localparam int DW = DATA_SIZE_DEF;
  localparam int MS = MAIN_SIZE_DEF;
  localparam int AW = ADDR_SIZE_DEF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW:0]   umbral_af = 3'd3, umbral_ae = 3'd1;
  logic          mem_write, mem_read, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem_data;
  logic [AW:0]   fifo_count;

  fifo_ctrl_4x8 dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .umbral_af(umbral_af), .umbral_ae(umbral_ae),
    .mem_write(mem_write), .mem_read(mem_read), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .mem_data(mem_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .fifo_count(fifo_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int            n_chk = 0, n_fail = 0;
  logic [DW-1:0] stor [MS];
  logic [DW-1:0] sb_q [$];
  int            m_cnt = 0, m_wr = 0, m_rd = 0;
  bit            m_ovf = 0, m_unf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(fifo_count), 32'(m_cnt));
    chk("wr_ptr", 32'(wr_ptr), 32'(m_wr));
    chk("rd_ptr", 32'(rd_ptr), 32'(m_rd));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("full", 32'(full), 32'(m_cnt == MS));
    chk("almost_full", 32'(almost_full), 32'(m_cnt >= int'(umbral_af)));
    chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= int'(umbral_ae)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // One clock of stimulus: drive, check at the falling edge, advance the model.
  task automatic step(input bit p, input bit q, input logic [DW-1:0] d);
    bit dpush, dpop;
    push = p; pop = q; data_in = d;
    @(negedge clk);
    check_state();
    dpop  = q && (m_cnt != 0);
    dpush = p && ((m_cnt != MS) || dpop);
    chk("mem_write", 32'(mem_write), 32'(dpush));
    chk("mem_read", 32'(mem_read), 32'(dpop));
    chk("mem_data", 32'(mem_data), 32'(d));
    if (mem_read) begin
      if (sb_q.size() > 0) chk("rd_data", 32'(stor[rd_ptr]), 32'(sb_q.pop_front()));
      else                 chk("rd_unexpected", 32'(mem_read), 32'(0));
    end
    if (mem_write) begin
      stor[wr_ptr] = d;
      sb_q.push_back(d);
    end
    if (dpush) m_wr = (m_wr + 1) % MS;
    if (dpop)  m_rd = (m_rd + 1) % MS;
    m_cnt += int'(dpush) - int'(dpop);
    if (p && !dpush) m_ovf = 1;
    if (q && !dpop)  m_unf = 1;
    @(posedge clk);
    #1;
    push = 0; pop = 0;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_clear();
    check_state();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset held: strobes must stay low even with requests present.
    push = 1; pop = 1;
    #3;
    chk("rst_mem_write", 32'(mem_write), 32'(0));
    chk("rst_mem_read", 32'(mem_read), 32'(0));
    check_state();
    push = 0; pop = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: idle after reset
    step(0, 0, 8'h00);
    chk("t1_empty", 32'(empty), 32'(1));
    chk("t1_count", 32'(fifo_count), 32'(0));

    // 2: fill and overflow
    umbral_af = 3'd3;
    step(1, 0, 8'hA1);
    step(1, 0, 8'hA2);
    chk("t2_af_at2", 32'(almost_full), 32'(0));
    step(1, 0, 8'hA3);
    chk("t2_af_at3", 32'(almost_full), 32'(1));
    chk("t2_full_at3", 32'(full), 32'(0));
    step(1, 0, 8'hA4);
    chk("t2_full_at4", 32'(full), 32'(1));
    chk("t2_wr_wrap", 32'(wr_ptr), 32'(0));
    step(1, 0, 8'hA5);
    chk("t2_overflow", 32'(overflow), 32'(1));
    chk("t2_count", 32'(fifo_count), 32'(4));

    // 3: drain and underflow
    umbral_ae = 3'd1;
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    chk("t3_ae_at1", 32'(almost_empty), 32'(1));
    chk("t3_rd_at3", 32'(rd_ptr), 32'(3));
    step(0, 1, 8'h00);
    chk("t3_empty", 32'(empty), 32'(1));
    chk("t3_rd_wrap", 32'(rd_ptr), 32'(0));
    step(0, 1, 8'h00);
    chk("t3_underflow", 32'(underflow), 32'(1));

    // 4: simultaneous on full; threshold above depth keeps almost_full low
    do_reset();
    umbral_af = 3'd5;
    for (int i = 0; i < MS; i++) step(1, 0, 8'hB0 + 8'(i));
    chk("t4_af_gt_depth", 32'(almost_full), 32'(0));
    step(1, 1, 8'hB5);
    chk("t4_count", 32'(fifo_count), 32'(4));
    chk("t4_wr", 32'(wr_ptr), 32'(1));
    chk("t4_rd", 32'(rd_ptr), 32'(1));
    chk("t4_overflow", 32'(overflow), 32'(0));
    for (int i = 0; i < MS; i++) step(0, 1, 8'h00);
    umbral_af = 3'd3;

    // 5: simultaneous on empty
    do_reset();
    step(1, 1, 8'hC1);
    chk("t5_count", 32'(fifo_count), 32'(1));
    chk("t5_underflow", 32'(underflow), 32'(1));
    step(0, 1, 8'h00);

    // 6: async reset between edges clears immediately
    do_reset();
    step(0, 1, 8'h00);
    step(1, 0, 8'hD1);
    step(1, 0, 8'hD2);
    @(negedge clk);
    push = 1;
    reset = 1'b0;
    #1;
    model_clear();
    chk("t6_wr", 32'(wr_ptr), 32'(0));
    chk("t6_count", 32'(fifo_count), 32'(0));
    chk("t6_underflow", 32'(underflow), 32'(0));
    chk("t6_mem_write", 32'(mem_write), 32'(0));
    check_state();
    push = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Random mix against the model
    for (int i = 0; i < 60; i++) begin
      umbral_af = 3'($urandom_range(0, 5));
      umbral_ae = 3'($urandom_range(0, 5));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_4x8.md
Name: fifo_ctrl_4x8

Overview:
- Pointer/flag controller sitting directly in front of the 4-entry x 8-bit FIFO storage array. It is the producer of that array's write, read, write-pointer and read-pointer controls.
- Accepts push/pop requests from the switching datapath and tracks occupancy. Raises full/empty/almost flags and sticky overflow/underflow errors.
- Drives the storage array's write/read strobes and pointers, and forwards write data unchanged.

Parameters:
- DATA_SIZE, 8, width of data words passed through to storage.
- MAIN_SIZE, 4, FIFO depth in entries; must be a power of 2, at least 2.
- ADDR_SIZE, 2, pointer width; equals log2(MAIN_SIZE).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  request to write data_in this cycle.
- pop  in  1  request to read the head entry this cycle.
- data_in  in  DATA_SIZE  write data.
- umbral_af  in  ADDR_SIZE+1  almost-full threshold.
- umbral_ae  in  ADDR_SIZE+1  almost-empty threshold.
- mem_write  out  1  write strobe to storage (combinational).
- mem_read  out  1  read strobe to storage (combinational).
- wr_ptr  out  ADDR_SIZE  write address (registered).
- rd_ptr  out  ADDR_SIZE  read address (registered).
- mem_data  out  DATA_SIZE  equals data_in.
- full  out  1  count == MAIN_SIZE.
- empty  out  1  count == 0.
- almost_full  out  1  count >= umbral_af.
- almost_empty  out  1  count <= umbral_ae.
- fifo_count  out  ADDR_SIZE+1  current occupancy, 0..MAIN_SIZE.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Reset (reset==0, async, takes effect immediately):
  - wr_ptr=0, rd_ptr=0, fifo_count=0, overflow=0, underflow=0.
  - Consequently empty=1, full=0, almost_empty=1; almost_full follows its formula.
  - mem_write=0 and mem_read=0 while reset is low, regardless of push/pop.
- Acceptance, computed from the current state combinationally:
  - do_pop = pop & ~empty.
  - do_push = push & (~full | do_pop). A push while full is accepted if a pop is accepted in the same cycle.
  - A push while empty is accepted. A simultaneous pop while empty is rejected; there is no bypass.
- mem_write = do_push and mem_read = do_pop, same cycle as the request. Storage read data is therefore valid in the request cycle.
- Registered updates on the clk rising edge:
  - wr_ptr increments on do_push, modulo MAIN_SIZE; it wraps from 3 to 0.
  - rd_ptr increments on do_pop, modulo MAIN_SIZE.
  - fifo_count: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Errors:
  - overflow sets when push & ~do_push.
  - underflow sets when pop & ~do_pop.
  - Both are sticky; only reset clears them.
- Flags are combinational decodes of the registered fifo_count and the threshold inputs. There is no extra latency: a flag changes in the cycle after the accepted transaction's edge.
- Threshold values above MAIN_SIZE are legal. With umbral_af > MAIN_SIZE, almost_full never asserts.
- Reset asserted mid-transaction: the in-flight request is dropped and pointers return to 0. Storage contents are not cleared by this block.
- The block has no FSM. State is the pointer pair, the count and the two sticky bits.

Decomposition:
- Shared package holds DATA_SIZE, MAIN_SIZE and ADDR_SIZE defaults, so this block and the storage array share one definition.
- Natural sub-module: fifo_ptr_4, a modulo-MAIN_SIZE incrementing pointer with enable and async active-low reset. It is instantiated twice, once for write and once for read.
- Count and flag logic stay in the top.

Test Plan:
1. Reset then idle: after reset release, empty=1, full=0, fifo_count=0, wr_ptr=rd_ptr=0, no strobes.
2. Fill and overflow (umbral_af=3):
   - Push 0xA1, 0xA2, 0xA3, 0xA4 on consecutive cycles, giving wr_ptr 0,1,2,3, then 0 after wrap.
   - almost_full rises after the 3rd push and full after the 4th.
   - A 5th push gives mem_write=0, overflow=1 and fifo_count stays 4.
3. Drain and underflow (umbral_ae=1):
   - Pop 4 times from full; rd_ptr advances 0 to 3 and wraps to 0.
   - almost_empty is 1 at count 1; empty=1 after the 4th pop.
   - A 5th pop gives mem_read=0 and underflow=1.
4. Simultaneous on full: with count=4, assert push and pop together. mem_write=1, mem_read=1, count stays 4, both pointers advance, overflow stays 0.
5. Simultaneous on empty: with count=0, assert push and pop together. mem_write=1, mem_read=0, count becomes 1, underflow=1.
6. Async reset mid-stream: after 2 pushes, pull reset low between clock edges. Pointers, count and sticky bits clear immediately, without waiting for an edge.
